// File: rtl/intt_gs_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly for Dilithium (q = 8380417).
// Three register stages: add/sub, multiply, modular reduction; valid/ready on both sides.
module intt_gs_butterfly #(
  parameter int unsigned W     = 23,
  parameter int unsigned Q     = 8380417,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_zeta,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_u,
  output logic [W-1:0]     out_v,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             err_sticky,
  output logic             busy
);

  localparam logic [W-1:0] Q_W = W'(Q);

  // Folds a 46-bit product three times using 2^23 == 2^13 - 1 (mod q), then one conditional subtract.
  function automatic logic [22:0] mod_q(input logic [45:0] p);
    logic [36:0] f1;
    logic [27:0] f2;
    logic [23:0] f3;
    f1 = {14'd0, p[22:0]} + {1'b0, p[45:23], 13'd0} - {14'd0, p[45:23]};
    f2 = {5'd0, f1[22:0]} + {1'b0, f1[36:23], 13'd0} - {14'd0, f1[36:23]};
    f3 = {1'b0, f2[22:0]} + {6'd0, f2[27:23], 13'd0} - {19'd0, f2[27:23]};
    if (f3 >= 24'd8380417) begin
      f3 = f3 - 24'd8380417;
    end else begin
      f3 = f3;
    end
    return f3[22:0];
  endfunction

  logic             adv_s;
  logic             range_err_s;
  logic [W:0]       sum_s;
  logic [W:0]       diff_s;
  logic [W-1:0]     u_next_s;
  logic [W-1:0]     d_next_s;

  logic             s1_valid_r, s2_valid_r, s3_valid_r;
  logic [W-1:0]     s1_u_r, s1_d_r, s1_zeta_r, s2_u_r;
  logic [TAG_W-1:0] s1_tag_r, s2_tag_r;
  logic             s1_err_r, s2_err_r;
  logic [2*W-1:0]   s2_p_r;

  assign adv_s     = !s3_valid_r || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = s3_valid_r;
  assign busy      = s1_valid_r || s2_valid_r || s3_valid_r;

  // First-stage arithmetic: one correction each for the sum and the difference; bad operands force zeros.
  always_comb begin
    range_err_s = (in_a >= Q_W) || (in_b >= Q_W) || (in_zeta >= Q_W);
    sum_s       = {1'b0, in_a} + {1'b0, in_b};
    diff_s      = {1'b0, in_a} - {1'b0, in_b};
    u_next_s    = sum_s[W-1:0];
    d_next_s    = diff_s[W-1:0];
    if (range_err_s) begin
      u_next_s = '0;
      d_next_s = '0;
    end else begin
      if (sum_s >= {1'b0, Q_W}) begin
        u_next_s = W'(sum_s - {1'b0, Q_W});
      end else begin
        u_next_s = sum_s[W-1:0];
      end
      if (diff_s[W]) begin
        d_next_s = diff_s[W-1:0] + Q_W;
      end else begin
        d_next_s = diff_s[W-1:0];
      end
    end
  end

  // Pipeline registers; every stage moves together so bubbles keep their slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_u_r     <= '0;
      s1_d_r     <= '0;
      s1_zeta_r  <= '0;
      s1_tag_r   <= '0;
      s1_err_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_u_r     <= '0;
      s2_p_r     <= '0;
      s2_tag_r   <= '0;
      s2_err_r   <= 1'b0;
      s3_valid_r <= 1'b0;
      out_u      <= '0;
      out_v      <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      s1_u_r     <= u_next_s;
      s1_d_r     <= d_next_s;
      s1_zeta_r  <= in_zeta;
      s1_tag_r   <= in_tag;
      s1_err_r   <= range_err_s;
      s2_valid_r <= s1_valid_r;
      s2_u_r     <= s1_u_r;
      s2_p_r     <= s1_d_r * s1_zeta_r;
      s2_tag_r   <= s1_tag_r;
      s2_err_r   <= s1_err_r;
      s3_valid_r <= s2_valid_r;
      out_u      <= s2_u_r;
      out_v      <= mod_q(s2_p_r);
      out_tag    <= s2_tag_r;
      out_err    <= s2_err_r;
    end else begin
      s1_valid_r <= s1_valid_r;
      s2_valid_r <= s2_valid_r;
      s3_valid_r <= s3_valid_r;
    end
  end

  // Sticky error flag, set when an errored beat actually leaves the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (s3_valid_r && out_ready && out_err) begin
      err_sticky <= 1'b1;
    end else begin
      err_sticky <= err_sticky;
    end
  end

endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Scoreboarded bench for intt_gs_butterfly: directed edge cases, stall, reset and random traffic
// checked against a plain-arithmetic reference of the butterfly equations.
module tb_intt_gs_butterfly;

  localparam longint QL = 64'd8380417;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] in_a, in_b, in_zeta;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_u, out_v;
  logic [7:0]  out_tag;
  logic        out_err;
  logic        err_sticky;
  logic        busy;

  typedef struct {
    logic [22:0] u;
    logic [22:0] v;
    logic [7:0]  tag;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   n_emit   = 0;
  int   n_disc   = 0;
  int   mode     = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random
  logic [7:0] tag_cnt = 8'd0;
  logic sticky_exp = 1'b0;

  intt_gs_butterfly dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_zeta(in_zeta), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_u(out_u), .out_v(out_v), .out_tag(out_tag), .out_err(out_err),
    .err_sticky(err_sticky), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference butterfly straight from the equations, with 64-bit arithmetic.
  function automatic exp_t model(input logic [22:0] a, input logic [22:0] b,
                                 input logic [22:0] z, input logic [7:0] tag);
    exp_t e;
    longint la, lb, lz;
    la = longint'(a);
    lb = longint'(b);
    lz = longint'(z);
    e.tag = tag;
    if (la >= QL || lb >= QL || lz >= QL) begin
      e.u = 23'd0;
      e.v = 23'd0;
      e.err = 1'b1;
    end else begin
      e.u = 23'((la + lb) % QL);
      e.v = 23'((((la - lb + QL) % QL) * lz) % QL);
      e.err = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [22:0] rnd_coef();
    int unsigned sel;
    sel = $urandom_range(0, 63);
    if (sel == 0) return 23'(QL + longint'($urandom_range(0, 8190)));
    if (sel == 1) return 23'(QL - 1);
    if (sel == 2) return 23'd0;
    return 23'($urandom_range(0, 8380416));
  endfunction

  // Present one beat, hold it until accepted, then record its expected result.
  task automatic send(input logic [22:0] a, input logic [22:0] b, input logic [22:0] z);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_zeta = z;
    in_tag = tag_cnt;
    #1;
    while (in_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(a, b, z, tag_cnt));
      n_acc++;
      tag_cnt = tag_cnt + 8'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pop and compare on every emitted beat; check hold-stable and back-pressure while stalled.
  initial begin
    exp_t e;
    logic stall_prev;
    logic [22:0] hu, hv;
    logic [7:0]  ht;
    logic        he;
    stall_prev = 1'b0;
    hu = '0; hv = '0; ht = '0; he = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && out_valid) begin
          chk("stall_hold_u", out_u, hu);
          chk("stall_hold_v", out_v, hv);
          chk("stall_hold_tag", out_tag, ht);
          chk("stall_hold_err", out_err, he);
        end
        if (out_valid && !out_ready) chk("in_ready_low_when_stalled", in_ready, 0);
        if (out_valid && out_ready) begin
          n_emit++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_tag", out_tag, -1);
          end else begin
            e = exp_q.pop_front();
            chk("out_tag", out_tag, e.tag);
            chk("out_u", out_u, e.u);
            chk("out_v", out_v, e.v);
            chk("out_err", out_err, e.err);
            chk("err_sticky", err_sticky, sticky_exp);
            sticky_exp = sticky_exp | e.err;
          end
        end
        stall_prev = out_valid && !out_ready;
        hu = out_u; hv = out_v; ht = out_tag; he = out_err;
      end
    end
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_zeta = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_u", out_u, 0);
    chk("reset_out_v", out_v, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_err_sticky", err_sticky, 0);

    // T1 with latency measurement on an empty, unstalled pipeline.
    send(23'd5, 23'd3, 23'd1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_edges", lat, 3);
    drain();

    // T2, T3 and edge values.
    send(23'd3, 23'd5, 23'd1);
    send(23'(QL - 1), 23'd1, 23'(QL - 1));
    send(23'd50, 23'd8380387, 23'd4190209);
    send(23'd1234567, 23'd1234567, 23'd777);
    send(23'd99, 23'd4, 23'd0);
    drain();

    // T4: eight beats into a stalled output, released after five cycles.
    mode = 1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_coef(), rnd_coef(), rnd_coef());
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        chk("t4_in_ready_stalled", in_ready, 0);
        chk("t4_out_valid_stalled", out_valid, 1);
        mode = 0;
      end
    join
    drain();

    // T5: out-of-range operand, then a legal beat.
    send(23'd8380417, 23'd1, 23'd1);
    send(23'd7, 23'd2, 23'd3);
    drain();
    @(negedge clk);
    #1;
    chk("t5_err_sticky_held", err_sticky, 1);

    // T6: reset with three beats in flight.
    send(rnd_coef(), rnd_coef(), rnd_coef());
    send(rnd_coef(), rnd_coef(), rnd_coef());
    send(rnd_coef(), rnd_coef(), rnd_coef());
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid_async", out_valid, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_err_sticky_cleared", err_sticky, 0);
    n_disc = n_disc + exp_q.size();
    exp_q.delete();
    sticky_exp = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mode = 1;
    @(negedge clk);
    #1;
    chk("t6_in_ready_after_release", in_ready, 1);
    mode = 0;
    send(23'd11, 23'd22, 23'd33);
    send(23'd8000000, 23'd8000000, 23'd5);
    drain();

    // Random traffic with random back-pressure and input gaps.
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) send(23'd4242, 23'd4242, rnd_coef());
      else send(rnd_coef(), rnd_coef(), rnd_coef());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    mode = 0;
    drain();
    repeat (4) @(negedge clk);
    chk("beats_conserved", n_emit + n_disc, n_acc);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
